// File: rtl/wb_slave_router.sv
// wb_slave_router: routes Wishbone cycles from the bridge master port to the
// register slave, the RAM slave, or an unmapped responder. Address, data and
// control are registered before they reach the slaves. Read data and the
// acknowledge are registered on the way back to the bridge.
// Optional watchdog: define WB_ROUTER_TIMEOUT_EN to abort BUSY transfers after
// TIMEOUT_CYCLES cycles without a slave ACK.
module wb_slave_router #(
  parameter int          ADDRWIDTH      = 10,
  parameter int          SEL_LSB        = 7,
  parameter int          REG_SEL        = 0,
  parameter int          RAM_SEL        = 1,
  parameter logic [31:0] UNMAPPED_VALUE = 32'hFABDEFAC,
  parameter logic [31:0] TIMEOUT_VALUE  = 32'h0BAD0ACC,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [31:0]          WBs_DAT_i,
  output logic [31:0]          WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic [SEL_LSB-1:0]   Slv_ADR_o,
  output logic [31:0]          Slv_DAT_o,
  output logic                 Slv_WE_o,
  output logic [3:0]           Slv_BYTE_STB_o,
  output logic                 Reg_CYC_o,
  output logic                 Reg_STB_o,
  input  logic                 Reg_ACK_i,
  input  logic [31:0]          Reg_DAT_i,
  output logic                 Ram_CYC_o,
  output logic                 Ram_STB_o,
  input  logic                 Ram_ACK_i,
  input  logic [31:0]          Ram_DAT_i,
  output logic                 Timeout_o,
  output logic [7:0]           Timeout_Cnt_o
);

  localparam int              SELW      = ADDRWIDTH - SEL_LSB;
  localparam logic [SELW-1:0] REG_SEL_V = SELW'(REG_SEL);
  localparam logic [SELW-1:0] RAM_SEL_V = SELW'(RAM_SEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ACK   = 2'd2,
    ST_UNMAP = 2'd3
  } state_e;

  state_e             state_q,   state_d;
  logic [SEL_LSB-1:0] slv_adr_q, slv_adr_d;
  logic [31:0]        slv_dat_q, slv_dat_d;
  logic               slv_we_q,  slv_we_d;
  logic [3:0]         slv_be_q,  slv_be_d;
  logic               sel_ram_q, sel_ram_d;
  logic [31:0]        wbs_dat_q, wbs_dat_d;

  logic [SELW-1:0]    adr_sel;
  logic               slv_ack;
  logic [31:0]        slv_rdat;
  logic               wdog_expired;

  assign adr_sel  = WBs_ADR_i[ADDRWIDTH-1:SEL_LSB];
  // Only the selected slave's ACK and data are ever looked at.
  assign slv_ack  = sel_ram_q ? Ram_ACK_i : Reg_ACK_i;
  assign slv_rdat = sel_ram_q ? Ram_DAT_i : Reg_DAT_i;

  // Next-state and datapath decode for the transfer FSM.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    slv_adr_d = slv_adr_q;
    slv_dat_d = slv_dat_q;
    slv_we_d  = slv_we_q;
    slv_be_d  = slv_be_q;
    sel_ram_d = sel_ram_q;
    wbs_dat_d = wbs_dat_q;
    case (state_q)
      ST_IDLE: begin
        if (WBs_CYC_i && WBs_STB_i) begin
          slv_adr_d = WBs_ADR_i[SEL_LSB-1:0];
          slv_dat_d = WBs_DAT_i;
          slv_we_d  = WBs_WE_i;
          slv_be_d  = WBs_BYTE_STB_i;
          sel_ram_d = (adr_sel == RAM_SEL_V);
          if ((adr_sel == REG_SEL_V) || (adr_sel == RAM_SEL_V)) state_d = ST_BUSY;
          else                                                  state_d = ST_UNMAP;
        end
      end
      ST_BUSY: begin
        // Master abandon beats everything; a real ACK beats the watchdog.
        if (!WBs_CYC_i) begin
          state_d = ST_IDLE;
        end else if (slv_ack) begin
          wbs_dat_d = slv_rdat;
          state_d   = ST_ACK;
        end else if (wdog_expired) begin
          wbs_dat_d = TIMEOUT_VALUE;
          state_d   = ST_ACK;
        end
      end
      ST_ACK:   state_d = ST_IDLE;
      ST_UNMAP: begin
        wbs_dat_d = UNMAPPED_VALUE;
        state_d   = ST_ACK;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and forwarded-signal registers with synchronous reset.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q   <= ST_IDLE;
      slv_adr_q <= '0;
      slv_dat_q <= '0;
      slv_we_q  <= 1'b0;
      slv_be_q  <= '0;
      sel_ram_q <= 1'b0;
      wbs_dat_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      slv_adr_q <= slv_adr_d;
      slv_dat_q <= slv_dat_d;
      slv_we_q  <= slv_we_d;
      slv_be_q  <= slv_be_d;
      sel_ram_q <= sel_ram_d;
      wbs_dat_q <= wbs_dat_d;
    end
  end

  assign WBs_DAT_o      = wbs_dat_q;
  assign WBs_ACK_o      = (state_q == ST_ACK);
  assign Slv_ADR_o      = slv_adr_q;
  assign Slv_DAT_o      = slv_dat_q;
  assign Slv_WE_o       = slv_we_q;
  assign Slv_BYTE_STB_o = slv_be_q;
  assign Reg_CYC_o      = (state_q == ST_BUSY) && !sel_ram_q;
  assign Reg_STB_o      = (state_q == ST_BUSY) && !sel_ram_q;
  assign Ram_CYC_o      = (state_q == ST_BUSY) &&  sel_ram_q;
  assign Ram_STB_o      = (state_q == ST_BUSY) &&  sel_ram_q;

`ifdef WB_ROUTER_TIMEOUT_EN
  logic [7:0] wdog_q,        wdog_d;
  logic       timeout_q,     timeout_d;
  logic [7:0] timeout_cnt_q, timeout_cnt_d;
  logic       timeout_hit;

  // The count equals the number of BUSY cycles so far, including the current one.
  assign wdog_expired = (wdog_q == 8'(TIMEOUT_CYCLES));
  assign timeout_hit  = (state_q == ST_BUSY) && WBs_CYC_i && !slv_ack && wdog_expired;

  // Watchdog count and the sticky/saturating abort statistics.
  always_comb begin
    wdog_d        = 8'd0;
    timeout_d     = timeout_q;
    timeout_cnt_d = timeout_cnt_q;
    if (state_d == ST_BUSY) wdog_d = (state_q == ST_BUSY) ? wdog_q + 8'd1 : 8'd1;
    if (timeout_hit) begin
      timeout_d = 1'b1;
      if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      wdog_q        <= 8'd0;
      timeout_q     <= 1'b0;
      timeout_cnt_q <= 8'd0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign Timeout_o     = timeout_q;
  assign Timeout_Cnt_o = timeout_cnt_q;
`else
  logic [7:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
  assign wdog_expired          = 1'b0;
  assign Timeout_o             = 1'b0;
  assign Timeout_Cnt_o         = 8'd0;
`endif

endmodule

// File: tb/tb_wb_slave_router.sv
// tb_wb_slave_router: randomized scoreboard bench for wb_slave_router.
// A driver issues master cycles and pushes the expected response (data, ACK
// cycle, watchdog statistics) into a queue; a monitor pops and compares on
// every WBs_ACK_o and also checks routing and forwarded slave signals.
module tb_wb_slave_router;

  localparam int          T_CYC   = 4;
  localparam logic [31:0] UNMAP_V = 32'hFABDEFAC;
  localparam logic [31:0] TMO_V   = 32'h0BAD0ACC;
  localparam int          R_NONE  = 0;
  localparam int          R_REG   = 1;
  localparam int          R_RAM   = 2;
`ifdef WB_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] dat;
    int          cyc;
    logic        to_flag;
    logic [7:0]  to_cnt;
  } exp_t;

  logic        clk, rst;
  logic [9:0]  adr;
  logic        cyc_i, stb, we;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic [31:0] WBs_DAT_o;
  logic        WBs_ACK_o;
  logic [6:0]  Slv_ADR_o;
  logic [31:0] Slv_DAT_o;
  logic        Slv_WE_o;
  logic [3:0]  Slv_BYTE_STB_o;
  logic        Reg_CYC_o, Reg_STB_o, Ram_CYC_o, Ram_STB_o;
  logic        reg_ack, ram_ack, reg_ack_m, ram_ack_m, inj_reg_ack, inj_ram_ack;
  logic [31:0] reg_dat, ram_dat;
  logic        Timeout_o;
  logic [7:0]  Timeout_Cnt_o;

  assign reg_ack = reg_ack_m | inj_reg_ack;
  assign ram_ack = ram_ack_m | inj_ram_ack;

  wb_slave_router #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr), .WBs_CYC_i(cyc_i),
    .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(be), .WBs_DAT_i(wdat),
    .WBs_DAT_o(WBs_DAT_o), .WBs_ACK_o(WBs_ACK_o), .Slv_ADR_o(Slv_ADR_o),
    .Slv_DAT_o(Slv_DAT_o), .Slv_WE_o(Slv_WE_o), .Slv_BYTE_STB_o(Slv_BYTE_STB_o),
    .Reg_CYC_o(Reg_CYC_o), .Reg_STB_o(Reg_STB_o), .Reg_ACK_i(reg_ack), .Reg_DAT_i(reg_dat),
    .Ram_CYC_o(Ram_CYC_o), .Ram_STB_o(Ram_STB_o), .Ram_ACK_i(ram_ack), .Ram_DAT_i(ram_dat),
    .Timeout_o(Timeout_o), .Timeout_Cnt_o(Timeout_Cnt_o)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  exp_t        sb_q[$];
  logic [31:0] ref_mem [2][128];
  logic [31:0] reg_mem [128];
  logic [31:0] ram_mem [128];
  int          ref_to_cnt;
  logic        ref_to_flag;
  logic [31:0] last_dat;
  bit          mon_en;
  int          cur_region;
  logic [6:0]  cur_adr;
  logic [31:0] cur_dat;
  logic        cur_we;
  logic [3:0]  cur_be;
  int          reg_dly, ram_dly, reg_cnt, ram_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] slave_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] m);
    logic [31:0] mask;
    mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Behavioural register and RAM slaves: ACK arrives dly cycles after the strobe.
  initial begin
    reg_ack_m = 1'b0; ram_ack_m = 1'b0; reg_dat = '0; ram_dat = '0;
    reg_cnt = 0; ram_cnt = 0;
    forever begin
      @(posedge clk); #1;
      reg_ack_m = 1'b0; reg_dat = $urandom;
      ram_ack_m = 1'b0; ram_dat = $urandom;
      if (Reg_STB_o === 1'b1) begin
        reg_cnt++;
        if (reg_cnt == reg_dly + 1) begin
          if (Slv_WE_o) reg_mem[Slv_ADR_o] = slave_merge(reg_mem[Slv_ADR_o], Slv_DAT_o, Slv_BYTE_STB_o);
          reg_dat   = reg_mem[Slv_ADR_o];
          reg_ack_m = 1'b1;
        end
      end else reg_cnt = 0;
      if (Ram_STB_o === 1'b1) begin
        ram_cnt++;
        if (ram_cnt == ram_dly + 1) begin
          if (Slv_WE_o) ram_mem[Slv_ADR_o] = slave_merge(ram_mem[Slv_ADR_o], Slv_DAT_o, Slv_BYTE_STB_o);
          ram_dat   = ram_mem[Slv_ADR_o];
          ram_ack_m = 1'b1;
        end
      end else ram_cnt = 0;
    end
  end

  // Monitor: scoreboard pop on every ACK, plus routing and hold checks each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (WBs_ACK_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", {31'd0, WBs_ACK_o}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ack_data",     WBs_DAT_o,     e.dat);
          check("ack_cycle",    cyc,           e.cyc);
          check("timeout_flag", Timeout_o,     e.to_flag);
          check("timeout_cnt",  Timeout_Cnt_o, e.to_cnt);
          last_dat = e.dat;
        end
      end else if (!rst) begin
        check("dat_hold", WBs_DAT_o, last_dat);
      end
      if (Reg_CYC_o || Reg_STB_o || Ram_CYC_o || Ram_STB_o) begin
        check("strobes", {Reg_CYC_o, Reg_STB_o, Ram_CYC_o, Ram_STB_o},
              (cur_region == R_REG) ? 4'b1100 : (cur_region == R_RAM) ? 4'b0011 : 4'b0000);
        check("slv_adr", Slv_ADR_o,      cur_adr);
        check("slv_dat", Slv_DAT_o,      cur_dat);
        check("slv_we",  Slv_WE_o,       cur_we);
        check("slv_be",  Slv_BYTE_STB_o, cur_be);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},     WBs_ACK_o,      0);
    check({tag, "_dat"},     WBs_DAT_o,      0);
    check({tag, "_slv_adr"}, Slv_ADR_o,      0);
    check({tag, "_slv_dat"}, Slv_DAT_o,      0);
    check({tag, "_slv_we"},  Slv_WE_o,       0);
    check({tag, "_slv_be"},  Slv_BYTE_STB_o, 0);
    check({tag, "_strobes"}, {Reg_CYC_o, Reg_STB_o, Ram_CYC_o, Ram_STB_o}, 0);
    check({tag, "_to"},      Timeout_o,      0);
    check({tag, "_to_cnt"},  Timeout_Cnt_o,  0);
  endtask

  function automatic int region_of(input logic [9:0] a);
    if (a[9:7] == 3'd0) return R_REG;
    if (a[9:7] == 3'd1) return R_RAM;
    return R_NONE;
  endfunction

  // One master cycle; called and returns just after a rising edge.
  task automatic do_xfer(input logic [9:0] a, input logic w, input logic [3:0] m,
                         input logic [31:0] d, input int dly, input bit inj_other);
    exp_t e;
    int   r;
    bit   got;
    r       = region_of(a);
    reg_dly = dly; ram_dly = dly;
    if (r == R_NONE) begin
      e.dat = UNMAP_V;
      e.cyc = cyc + 2;
    end else if (TO_EN && dly >= T_CYC) begin
      e.dat = TMO_V;
      e.cyc = cyc + T_CYC + 1;
      ref_to_flag = 1'b1;
      if (ref_to_cnt < 255) ref_to_cnt++;
    end else begin
      if (w) for (int b = 0; b < 4; b++) if (m[b]) ref_mem[r-1][a[6:0]][b*8 +: 8] = d[b*8 +: 8];
      e.dat = ref_mem[r-1][a[6:0]];
      e.cyc = cyc + 2 + dly;
    end
    e.to_flag = ref_to_flag;
    e.to_cnt  = 8'(ref_to_cnt);
    sb_q.push_back(e);
    cur_region = r; cur_adr = a[6:0]; cur_dat = d; cur_we = w; cur_be = m;
    adr = a; we = w; be = m; wdat = d; cyc_i = 1'b1; stb = 1'b1;
    if (inj_other) begin
      inj_reg_ack = (r != R_REG);
      inj_ram_ack = (r != R_RAM);
    end
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk); #1;
      if (WBs_ACK_o === 1'b1) got = 1'b1;
    end
    inj_reg_ack = 1'b0; inj_ram_ack = 1'b0;
    cur_region  = R_NONE;
    if (!got) begin
      check("ack_wait_expired", 0, 1);
      void'(sb_q.pop_front());
    end
    @(posedge clk); #1;
    cyc_i = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Starts a register-slave read that the slave will never acknowledge.
  task automatic start_stuck(input logic [9:0] a);
    reg_dly = 1000; ram_dly = 1000;
    cur_region = R_REG; cur_adr = a[6:0]; cur_dat = 32'h1234_5678; cur_we = 1'b0; cur_be = 4'hF;
    adr = a; we = 1'b0; be = 4'hF; wdat = 32'h1234_5678; cyc_i = 1'b1; stb = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; cyc_i = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; be = '0; wdat = '0;
    inj_reg_ack = 1'b0; inj_ram_ack = 1'b0; reg_dly = 0; ram_dly = 0;
    cur_region = R_NONE; cur_adr = '0; cur_dat = '0; cur_we = 1'b0; cur_be = '0;
    ref_to_cnt = 0; ref_to_flag = 1'b0; last_dat = '0; mon_en = 1'b0;
    for (int i = 0; i < 128; i++) begin
      reg_mem[i] = $urandom; ref_mem[0][i] = reg_mem[i];
      ram_mem[i] = $urandom; ref_mem[1][i] = ram_mem[i];
    end
    reg_mem[1] = 32'h0000_0100; ref_mem[0][1] = 32'h0000_0100;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed: register read, RAM write, unmapped read, non-selected ACK.
    do_xfer(10'h001, 1'b0, 4'hF, 32'h0,         1, 1'b0);
    do_xfer(10'h085, 1'b1, 4'hF, 32'hA5A5_1234, 0, 1'b0);
    do_xfer(10'h085, 1'b0, 4'hF, 32'h0,         2, 1'b0);
    do_xfer(10'h200, 1'b0, 4'hF, 32'h0,         1, 1'b0);
    do_xfer(10'h2C5, 1'b1, 4'hF, 32'hDEAD_BEEF, 1, 1'b1);
    do_xfer(10'h010, 1'b0, 4'hF, 32'h0,         2, 1'b1);

    // Randomized traffic across all regions, byte enables and slave latencies.
    for (int n = 0; n < 150; n++) begin
      int          sel;
      logic [9:0]  a;
      sel = $urandom_range(0, 9);
      a   = 10'($urandom);
      a[9:7] = (sel < 4) ? 3'd0 : (sel < 8) ? 3'd1 : 3'($urandom_range(2, 7));
      do_xfer(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0));
    end

    // Master abandons on the 2nd BUSY cycle; a late slave ACK must be ignored.
    start_stuck(10'h002);
    cyc_i = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    cur_region  = R_NONE;
    inj_reg_ack = 1'b1;
    @(negedge clk);
    check("abandon_strobes", {Reg_CYC_o, Reg_STB_o, Ram_CYC_o, Ram_STB_o}, 4'b0000);
    @(posedge clk); #1;
    inj_reg_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abandon_no_ack", WBs_ACK_o, 1'b0);
    end
    @(posedge clk); #1;

`ifdef WB_ROUTER_TIMEOUT_EN
    // ACK in the expiry cycle wins, then watchdog aborts until the count saturates.
    do_xfer(10'h003, 1'b0, 4'hF, 32'h0, T_CYC - 1, 1'b0);
    do_xfer(10'h003, 1'b0, 4'hF, 32'h0, 1000, 1'b0);
    for (int n = 1; n < 300; n++)
      do_xfer({2'b00, 1'($urandom), 7'($urandom)}, 1'($urandom), 4'($urandom), $urandom, 1000, 1'b0);
    @(negedge clk);
    check("timeout_saturated", Timeout_Cnt_o, 8'hFF);
    @(posedge clk); #1;
    do_xfer(10'h004, 1'b0, 4'hF, 32'h0, 2, 1'b0);
`endif

    // Reset pulsed in BUSY: everything clears, a late ACK is ignored.
    start_stuck(10'h005);
    rst = 1'b1; cyc_i = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; cur_region = R_NONE; last_dat = '0;
    ref_to_cnt = 0; ref_to_flag = 1'b0;
    inj_reg_ack = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    inj_reg_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    do_xfer(10'h001, 1'b0, 4'hF, 32'h0, 1, 1'b0);
    do_xfer(10'h0C7, 1'b1, 4'h5, 32'h1357_9BDF, 3, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
